// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Sequences one DATARAM access per request: direct byte, register Rn,
//   indirect @Ri (pointer fetch then data access) or bit-addressed.
//   All outputs come straight from flops. Each output's next value is decided
//   together with the next state, so every output is valid for the whole
//   cycle spent in the state it belongs to.
//
// Handshake: req is sampled only while busy is low (IDLE). When req=1 is
//   seen in IDLE, the request fields are captured on that edge and busy rises
//   on the following cycle. Later changes to req or the request fields have no
//   effect until ack has pulsed for one cycle and busy has dropped again.
//
// Configuration: RAM_ACC_BANK_EN
//   defined   -> the bank input selects the register bank for Rn / @Ri.
//   undefined -> bank is ignored and bank bits read as 2'b00.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req, mode, wr          request, addressing mode, 1 = write
//   operand, wdata, wbit   address/index operand, byte and bit write data
//   bank                   register bank select (PSW RS1:RS0)
//   busy, ack              busy outside IDLE, one-cycle completion pulse
//   rdata, rbit            last completed read data (byte and bit)
//   ram_CS .. ram_bin      DATARAM port drive (CS active-low, RW 1 = read,
//                          Bb 1 = byte)
//   ram_dout, ram_bout     DATARAM read data, valid the cycle after CS-low read
//   dbg_state              current FSM state, for observation only
module ram_access_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] mode,
  input  logic       wr,
  input  logic [7:0] operand,
  input  logic [7:0] wdata,
  input  logic       wbit,
  input  logic [1:0] bank,
  output logic       busy,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       rbit,
  output logic       ram_CS,
  output logic       ram_RW,
  output logic       ram_Bb,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_position,
  output logic [7:0] ram_din,
  output logic       ram_bin,
  input  logic [7:0] ram_dout,
  input  logic       ram_bout,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PTR_RD  = 3'd1,
    PTR_CAP = 3'd2,
    ISSUE   = 3'd3,
    CAPT    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_RN     = 2'b01;
  localparam logic [1:0] MODE_RI     = 2'b10;
  localparam logic [1:0] MODE_BIT    = 2'b11;

  state_t state, state_n;

  // Request fields captured at acceptance
  logic [1:0] mode_q;
  logic       wr_q;
  logic [7:0] op_q;
  logic [7:0] wdata_q;
  logic       wbit_q;
  logic [1:0] bank_q;
  logic [7:0] pointer, pointer_n;

  logic       busy_n, ack_n, rbit_n;
  logic [7:0] rdata_n;
  logic       cs_n, rw_n, bb_n, bin_n;
  logic [7:0] addr_n, pos_n, din_n;
  logic [1:0] bank_eff;

`ifdef RAM_ACC_BANK_EN
  assign bank_eff = bank;
`else
  assign bank_eff = 2'b00;
`endif

  assign dbg_state = state;

  // Data-access address for the ISSUE cycle.
  // Bit space: 00-7F maps onto bytes 20-2F, 80-FF onto SFR bytes (x & F8).
  function automatic logic [7:0] issue_addr(input logic [1:0] m,
                                            input logic [7:0] op,
                                            input logic [1:0] bk,
                                            input logic [7:0] ptr);
    logic [7:0] a;
    case (m)
      MODE_DIRECT: a = op;
      MODE_RN:     a = {3'b000, bk, op[2:0]};
      MODE_RI:     a = ptr;
      default:     a = op[7] ? (op & 8'hF8) : (8'h20 + {4'h0, op[6:3]});
    endcase
    return a;
  endfunction

  function automatic logic [7:0] issue_pos(input logic [1:0] m,
                                           input logic [7:0] op);
    return (m == MODE_BIT) ? (8'h01 << op[2:0]) : 8'h00;
  endfunction

  always_comb begin
    state_n   = state;
    pointer_n = pointer;
    ack_n     = 1'b0;
    rdata_n   = rdata;
    rbit_n    = rbit;
    cs_n      = 1'b1;
    rw_n      = ram_RW;
    bb_n      = ram_Bb;
    addr_n    = ram_addr;
    pos_n     = ram_position;
    din_n     = ram_din;
    bin_n     = ram_bin;

    case (state)
      IDLE: begin
        if (req) begin
          if (mode == MODE_RI) begin
            // Fetch the pointer from Ri of the selected bank
            state_n = PTR_RD;
            cs_n    = 1'b0;
            rw_n    = 1'b1;
            bb_n    = 1'b1;
            addr_n  = {3'b000, bank_eff, 2'b00, operand[0]};
            pos_n   = 8'h00;
          end else begin
            state_n = ISSUE;
            cs_n    = 1'b0;
            rw_n    = ~wr;
            bb_n    = (mode != MODE_BIT);
            addr_n  = issue_addr(mode, operand, bank_eff, pointer);
            pos_n   = issue_pos(mode, operand);
            din_n   = wdata;
            bin_n   = wbit;
          end
        end
      end
      PTR_RD: state_n = PTR_CAP;
      PTR_CAP: begin
        // ram_dout carries Ri now; it is both the stored pointer and the
        // address of the data access that follows.
        pointer_n = ram_dout;
        state_n   = ISSUE;
        cs_n      = 1'b0;
        rw_n      = ~wr_q;
        bb_n      = 1'b1;
        addr_n    = ram_dout;
        pos_n     = 8'h00;
        din_n     = wdata_q;
        bin_n     = wbit_q;
      end
      ISSUE: begin
        if (wr_q) begin
          state_n = DONE;
          ack_n   = 1'b1;
        end else begin
          state_n = CAPT;
        end
      end
      CAPT: begin
        rdata_n = ram_dout;
        rbit_n  = ram_bout;
        state_n = DONE;
        ack_n   = 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pointer      <= 8'h00;
      busy         <= 1'b0;
      ack          <= 1'b0;
      rdata        <= 8'h00;
      rbit         <= 1'b0;
      ram_CS       <= 1'b1;
      ram_RW       <= 1'b1;
      ram_Bb       <= 1'b1;
      ram_addr     <= 8'h00;
      ram_position <= 8'h00;
      ram_din      <= 8'h00;
      ram_bin      <= 1'b0;
      mode_q       <= 2'b00;
      wr_q         <= 1'b0;
      op_q         <= 8'h00;
      wdata_q      <= 8'h00;
      wbit_q       <= 1'b0;
      bank_q       <= 2'b00;
    end else begin
      state        <= state_n;
      pointer      <= pointer_n;
      busy         <= busy_n;
      ack          <= ack_n;
      rdata        <= rdata_n;
      rbit         <= rbit_n;
      ram_CS       <= cs_n;
      ram_RW       <= rw_n;
      ram_Bb       <= bb_n;
      ram_addr     <= addr_n;
      ram_position <= pos_n;
      ram_din      <= din_n;
      ram_bin      <= bin_n;
      if (state == IDLE && req) begin
        mode_q  <= mode;
        wr_q    <= wr;
        op_q    <= operand;
        wdata_q <= wdata;
        wbit_q  <= wbit;
        bank_q  <= bank_eff;
      end
    end
  end

  // mode_q, op_q and bank_q are held for observability of the captured
  // request; the data access after the pointer fetch needs only wr/wdata/wbit.
  logic unused_ok;
  assign unused_ok = ^{mode_q, op_q, bank_q};

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] mode;
  logic       wr;
  logic [7:0] operand;
  logic [7:0] wdata;
  logic       wbit;
  logic [1:0] bank;
  logic       busy, ack, rbit;
  logic [7:0] rdata;
  logic       ram_CS, ram_RW, ram_Bb, ram_bin;
  logic [7:0] ram_addr, ram_position, ram_din;
  logic [7:0] ram_dout;
  logic       ram_bout;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  ram_access_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .wr(wr),
    .operand(operand), .wdata(wdata), .wbit(wbit), .bank(bank),
    .busy(busy), .ack(ack), .rdata(rdata), .rbit(rbit),
    .ram_CS(ram_CS), .ram_RW(ram_RW), .ram_Bb(ram_Bb),
    .ram_addr(ram_addr), .ram_position(ram_position),
    .ram_din(ram_din), .ram_bin(ram_bin),
    .ram_dout(ram_dout), .ram_bout(ram_bout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // DATARAM model: read data appears the cycle after a CS-low read cycle
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (!ram_CS) begin
      if (ram_RW) begin
        ram_dout <= mem[ram_addr];
        ram_bout <= |(mem[ram_addr] & ram_position);
      end else if (ram_Bb) begin
        mem[ram_addr] <= ram_din;
      end else if (ram_bin) begin
        mem[ram_addr] <= mem[ram_addr] | ram_position;
      end else begin
        mem[ram_addr] <= mem[ram_addr] & ~ram_position;
      end
    end
  end

  // port monitor, sampled mid-cycle
  int         cs_total  = 0;
  int         ack_total = 0;
  logic [7:0] prev_addr, last_addr, last_pos, last_din;
  logic       last_rw, last_bb, last_bin;
  always @(negedge clk) begin
    if (!ram_CS) begin
      cs_total  <= cs_total + 1;
      prev_addr <= last_addr;
      last_addr <= ram_addr;
      last_pos  <= ram_position;
      last_din  <= ram_din;
      last_rw   <= ram_RW;
      last_bb   <= ram_Bb;
      last_bin  <= ram_bin;
    end
    if (ack) ack_total <= ack_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one access; lat = negedges after the accept edge until ack seen
  // (99 on timeout). hold keeps req high and scrambles the fields while busy.
  task automatic access(input logic [1:0] m, input logic w, input logic [7:0] op,
                        input logic [7:0] wd, input logic wb, input logic [1:0] bk,
                        input bit hold, output int lat);
    @(negedge clk);
    req = 1'b1; mode = m; wr = w; operand = op; wdata = wd; wbit = wb; bank = bk;
    @(posedge clk);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (hold) begin
        operand = 8'h0F; wdata = 8'hEE; mode = MODE_X(); wr = ~w;
      end else begin
        req = 1'b0;
      end
      if (ack) begin
        lat = i;
        break;
      end
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [1:0] MODE_X();
    return 2'($urandom_range(0, 3));
  endfunction

  int lat, cs0, ack0;
  logic [7:0] exp_rn_addr, exp_rn_data;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h0F] = 8'hA5; mem[8'h07] = 8'h5A;
    mem[8'h01] = 8'h40; mem[8'h40] = 8'h3C;
    mem[8'h90] = 8'h04; mem[8'h00] = 8'h50;
`ifdef RAM_ACC_BANK_EN
    exp_rn_addr = 8'h0F; exp_rn_data = 8'hA5;
`else
    exp_rn_addr = 8'h07; exp_rn_data = 8'h5A;
`endif
    ram_dout = 8'h00; ram_bout = 1'b0;
    req = 0; mode = 0; wr = 0; operand = 0; wdata = 0; wbit = 0; bank = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_cs", ram_CS, 1);
    chk("rst_rw", ram_RW, 1);
    chk("rst_bb", ram_Bb, 1);
    chk("rst_addr", ram_addr, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;

    // direct write
    cs0 = cs_total; ack0 = ack_total;
    access(2'b00, 1, 8'h30, 8'h55, 0, 2'b00, 0, lat);
    chk("dw_lat", lat, 2);
    chk("dw_cs_cnt", cs_total - cs0, 1);
    chk("dw_addr", last_addr, 8'h30);
    chk("dw_rw", last_rw, 0);
    chk("dw_bb", last_bb, 1);
    chk("dw_din", last_din, 8'h55);
    chk("dw_mem", mem[8'h30], 8'h55);
    chk("dw_busy_after", busy, 0);

    // Rn read, bank 01
    access(2'b01, 0, 8'h07, 8'h00, 0, 2'b01, 0, lat);
    chk("rn_lat", lat, 3);
    chk("rn_addr", last_addr, exp_rn_addr);
    chk("rn_rdata", rdata, exp_rn_data);

    // @Ri read
    cs0 = cs_total;
    access(2'b10, 0, 8'h01, 8'h00, 0, 2'b00, 0, lat);
    chk("ri_lat", lat, 5);
    chk("ri_cs_cnt", cs_total - cs0, 2);
    chk("ri_ptr_addr", prev_addr, 8'h01);
    chk("ri_data_addr", last_addr, 8'h40);
    chk("ri_rdata", rdata, 8'h3C);

    // bit write
    access(2'b11, 1, 8'h12, 8'h00, 1, 2'b00, 0, lat);
    chk("bw_lat", lat, 2);
    chk("bw_addr", last_addr, 8'h22);
    chk("bw_pos", last_pos, 8'h04);
    chk("bw_bb", last_bb, 0);
    chk("bw_bin", last_bin, 1);
    chk("bw_mem", mem[8'h22], 8'h04);
    chk("bw_rdata_hold", rdata, 8'h3C);

    // bit read of SFR bit 0x92
    access(2'b11, 0, 8'h92, 8'h00, 0, 2'b00, 0, lat);
    chk("br_lat", lat, 3);
    chk("br_addr", last_addr, 8'h90);
    chk("br_pos", last_pos, 8'h04);
    chk("br_rbit", rbit, 1);

    // @Ri write through R0 (RAM[00]=50)
    access(2'b10, 1, 8'h00, 8'h77, 0, 2'b00, 0, lat);
    chk("riw_lat", lat, 4);
    chk("riw_mem", mem[8'h50], 8'h77);

    // reset during PTR_CAP of an @Ri access
    cs0 = cs_total; ack0 = ack_total;
    @(negedge clk);
    req = 1; mode = 2'b10; wr = 0; operand = 8'h01;
    @(posedge clk);            // accept -> PTR_RD
    @(negedge clk); req = 0;
    @(negedge clk);            // in PTR_CAP
    chk("abort_in_ptrcap", dbg_state, 3'd2);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_rdata", rdata, 8'h00);
    repeat (6) @(negedge clk);
    chk("abort_cs_cnt", cs_total - cs0, 1);
    chk("abort_no_ack", ack_total - ack0, 0);

    // reset during ISSUE of a direct read
    ack0 = ack_total;
    @(negedge clk);
    req = 1; mode = 2'b00; wr = 0; operand = 8'h30;
    @(posedge clk);
    @(negedge clk); req = 0;
    chk("abort2_in_issue", dbg_state, 3'd3);
    rst = 1;
    @(negedge clk); rst = 0;
    repeat (5) @(negedge clk);
    chk("abort2_no_ack", ack_total - ack0, 0);
    chk("abort2_idle", dbg_state, 3'd0);

    // req held high with changing fields while busy
    cs0 = cs_total; ack0 = ack_total;
    access(2'b00, 0, 8'h30, 8'h00, 0, 2'b00, 1, lat);
    repeat (4) @(negedge clk);
    chk("hold_lat", lat, 3);
    chk("hold_cs_cnt", cs_total - cs0, 1);
    chk("hold_addr", last_addr, 8'h30);
    chk("hold_ack_cnt", ack_total - ack0, 1);
    chk("hold_rdata", rdata, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
